sdio_cmd_arb: RTL and testbench
===============================

SDIO_CMD_ARB -- requirements
Module: sdio_cmd_arb

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first: sd_clk in 1 SD clock; rstn in 1 asynchronous active-low reset.
REQ-002 SHALL have: sd_rst in 1 synchronous soft reset; sw_req in 1 software command request (level); sw_index in 6; sw_arg in 32; sw_resp_type in 2.
REQ-003 SHALL have: ac_req in 1 auto-CMD12 request from data engine (level); ac_arg in 32; auto index fixed 6'd12, resp_type fixed 2'b11.
REQ-004 SHALL have to engine: cmd_start out 1; cmd_index out 6; cmd_argument out 32; resp_type out 2; cmd_abort out 1 (drives engine soft reset).
REQ-005 SHALL have from engine: cmd_busy in 1; cmd_done in 1; cmd_timeout_err_event, resp_index_err_event, resp_crc_err_event, resp_end_err_event in 1 each.
REQ-006 SHALL have: sw_done out 1; ac_done out 1; cmd_err out 4 {end,crc,index,timeout}; arb_owner out 1 (0 sw, 1 auto); arb_busy out 1.

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, REPORT.
REQ-008 IDLE: if ac_req -> ISSUE, owner=1; else if sw_req -> ISSUE, owner=0; ac_req SHALL win simultaneous requests.
REQ-009 Index/argument/resp_type SHALL be latched at grant and held stable until return to IDLE; requester changes after grant ignored.
REQ-010 ISSUE: cmd_start=1 for exactly one cycle (registered), next state WAIT_BUSY; latency req-to-cmd_start = 1 cycle.
REQ-011 WAIT_BUSY: cmd_busy=1 -> WAIT_DONE; 4-cycle guard counter expiry without cmd_busy -> ABORT with timeout bit set.
REQ-012 WAIT_DONE: error events SHALL OR into sticky err register each cycle; cmd_done -> REPORT, including events coincident with cmd_done.
REQ-013 WAIT_DONE: cmd_timeout_err_event -> ABORT; engine does not self-exit on timeout.
REQ-014 ABORT: cmd_abort=1 for one cycle, then REPORT.
REQ-015 REPORT: one-cycle done pulse to owner (sw_done or ac_done) with cmd_err valid the same cycle; next IDLE.
REQ-016 cmd_err SHALL hold last result until next grant; cleared to 0 at grant.
REQ-017 Requester SHALL drop req upon its done; a req still high in IDLE after done SHALL be treated as a new request.
REQ-018 arb_busy = (state != IDLE); arb_owner valid while arb_busy.
REQ-019 sw_req arriving while busy SHALL be held pending (level) and served next, after any ac_req.

Reset
REQ-020 rstn low: state IDLE; cmd_start, cmd_abort, sw_done, ac_done, arb_busy, arb_owner = 0; cmd_err = 0; cmd_index = 0; cmd_argument = 0; resp_type = 0; guard/retry counters = 0.
REQ-021 sd_rst high: same values as rstn, synchronous, any state; no done pulse for the aborted command.
REQ-022 rstn deassertion mid-request: ISSUE reached no earlier than second sd_clk edge after release.

Configuration
REQ-023 With SDIO_CMD_ARB_RETRY_EN defined: crc or end error at REPORT with retry count 0 -> clear err, retry count 1, re-enter ISSUE, no done pulse; second result reported unconditionally.
REQ-024 Without SDIO_CMD_ARB_RETRY_EN: no retry logic present; every completion reported once.

Verification
REQ-025 sw_req with index 17, arg 0x0000_0200, type 2'b10; engine clean -> cmd_start 1 cycle later with those values; one sw_done pulse; cmd_err=0.
REQ-026 sw_req and ac_req same cycle, ac_arg 0 -> auto served first (cmd_index 12, type 2'b11); ac_done; then sw command issued; sw_done.
REQ-027 Engine pulses cmd_timeout_err_event in WAIT_DONE -> cmd_abort 1 cycle; sw_done with cmd_err=4'b0001.
REQ-028 resp_crc_err_event coincident with cmd_done -> cmd_err=4'b0100 (no retry build); retry build: second cmd_start, clean second pass gives cmd_err=0.
REQ-029 cmd_busy never asserts after cmd_start -> ABORT after 4 cycles, cmd_err=4'b0001; sd_rst asserted in WAIT_DONE -> IDLE next cycle, no done pulse.

Source files
------------

// File: rtl/sdio_cmd_arb.sv
// SDIO command arbiter: grants the shared command engine to software or auto-CMD12 requests.
// Optional build macro SDIO_CMD_ARB_RETRY_EN adds one automatic retry on CRC/end-bit errors.
module sdio_cmd_arb (
    input  logic        sd_clk,
    input  logic        rstn,
    input  logic        sd_rst,
    input  logic        sw_req,
    input  logic [5:0]  sw_index,
    input  logic [31:0] sw_arg,
    input  logic [1:0]  sw_resp_type,
    input  logic        ac_req,
    input  logic [31:0] ac_arg,
    output logic        cmd_start,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    output logic [1:0]  resp_type,
    output logic        cmd_abort,
    input  logic        cmd_busy,
    input  logic        cmd_done,
    input  logic        cmd_timeout_err_event,
    input  logic        resp_index_err_event,
    input  logic        resp_crc_err_event,
    input  logic        resp_end_err_event,
    output logic        sw_done,
    output logic        ac_done,
    output logic [3:0]  cmd_err,
    output logic        arb_owner,
    output logic        arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ABORT     = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  guard_r, guard_s;
    logic [3:0]  err_r, err_s;
    logic [3:0]  evt_s;
    logic        grant_s, grant_ac_s, retry_hit_s, retry_take_s;
    logic        ready_r;
    logic        cmd_start_r, cmd_abort_r, sw_done_r, ac_done_r, owner_r, busy_r;
    logic [5:0]  index_r;
    logic [31:0] arg_r;
    logic [1:0]  type_r;
`ifdef SDIO_CMD_ARB_RETRY_EN
    logic        retry_r;
`endif

    assign evt_s = {resp_end_err_event, resp_crc_err_event, resp_index_err_event, cmd_timeout_err_event};

    // Blocks grants on the first edge after reset release so ISSUE comes no earlier than the second.
    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Next-state, error accumulation and grant decode.
    always_comb begin
        state_s      = state_r;
        guard_s      = guard_r;
        err_s        = err_r;
        grant_s      = 1'b0;
        grant_ac_s   = 1'b0;
        retry_hit_s  = 1'b0;
        retry_take_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (ready_r && ac_req) begin
                    state_s    = S_ISSUE;
                    grant_s    = 1'b1;
                    grant_ac_s = 1'b1;
                    err_s      = 4'b0000;
                end else if (ready_r && sw_req) begin
                    state_s = S_ISSUE;
                    grant_s = 1'b1;
                    err_s   = 4'b0000;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_s = S_WAIT_BUSY;
                guard_s = 2'd0;
            end
            S_WAIT_BUSY: begin
                if (cmd_busy) begin
                    state_s = S_WAIT_DONE;
                end else if (guard_r == 2'd3) begin
                    state_s  = S_ABORT;
                    err_s[0] = 1'b1;
                end else begin
                    guard_s = guard_r + 2'd1;
                end
            end
            S_WAIT_DONE: begin
                err_s = err_r | evt_s;
                // The engine never leaves on its own after a timeout, so it must be aborted.
                if (cmd_timeout_err_event) begin
                    state_s = S_ABORT;
                end else if (cmd_done) begin
                    state_s = S_REPORT;
                end else begin
                    state_s = S_WAIT_DONE;
                end
            end
            S_ABORT: begin
                state_s = S_REPORT;
            end
            S_REPORT: begin
`ifdef SDIO_CMD_ARB_RETRY_EN
                if (!retry_r && (err_r[3] || err_r[2])) begin
                    state_s      = S_ISSUE;
                    err_s        = 4'b0000;
                    retry_take_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
`else
                state_s = S_IDLE;
`endif
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
`ifdef SDIO_CMD_ARB_RETRY_EN
        if (state_s == S_REPORT) begin
            retry_hit_s = !retry_r && (err_s[3] || err_s[2]);
        end else begin
            retry_hit_s = 1'b0;
        end
`endif
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            guard_r     <= 2'd0;
            err_r       <= 4'b0000;
            cmd_start_r <= 1'b0;
            cmd_abort_r <= 1'b0;
            sw_done_r   <= 1'b0;
            ac_done_r   <= 1'b0;
            owner_r     <= 1'b0;
            busy_r      <= 1'b0;
            index_r     <= 6'd0;
            arg_r       <= 32'd0;
            type_r      <= 2'd0;
        end else if (sd_rst) begin
            state_r     <= S_IDLE;
            guard_r     <= 2'd0;
            err_r       <= 4'b0000;
            cmd_start_r <= 1'b0;
            cmd_abort_r <= 1'b0;
            sw_done_r   <= 1'b0;
            ac_done_r   <= 1'b0;
            owner_r     <= 1'b0;
            busy_r      <= 1'b0;
            index_r     <= 6'd0;
            arg_r       <= 32'd0;
            type_r      <= 2'd0;
        end else begin
            state_r     <= state_s;
            guard_r     <= guard_s;
            err_r       <= err_s;
            cmd_start_r <= (state_s == S_ISSUE);
            cmd_abort_r <= (state_s == S_ABORT);
            sw_done_r   <= (state_s == S_REPORT) && !retry_hit_s && !owner_r;
            ac_done_r   <= (state_s == S_REPORT) && !retry_hit_s && owner_r;
            busy_r      <= (state_s != S_IDLE);
            if (grant_s) begin
                owner_r <= grant_ac_s;
                index_r <= grant_ac_s ? 6'd12 : sw_index;
                arg_r   <= grant_ac_s ? ac_arg : sw_arg;
                type_r  <= grant_ac_s ? 2'b11 : sw_resp_type;
            end else begin
                owner_r <= owner_r;
                index_r <= index_r;
                arg_r   <= arg_r;
                type_r  <= type_r;
            end
        end
    end

`ifdef SDIO_CMD_ARB_RETRY_EN
    // Retry budget: armed fresh at every grant, spent when a retry is taken.
    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            retry_r <= 1'b0;
        end else if (sd_rst) begin
            retry_r <= 1'b0;
        end else if (grant_s) begin
            retry_r <= 1'b0;
        end else if (retry_take_s) begin
            retry_r <= 1'b1;
        end else begin
            retry_r <= retry_r;
        end
    end
`endif

    assign cmd_start    = cmd_start_r;
    assign cmd_abort    = cmd_abort_r;
    assign sw_done      = sw_done_r;
    assign ac_done      = ac_done_r;
    assign cmd_err      = err_r;
    assign arb_owner    = owner_r;
    assign arb_busy     = busy_r;
    assign cmd_index    = index_r;
    assign cmd_argument = arg_r;
    assign resp_type    = type_r;

endmodule

// File: tb/tb_sdio_cmd_arb.sv
// Scoreboard bench for sdio_cmd_arb: stimulus pushes expected commands/completions, monitors compare.
module tb_sdio_cmd_arb;

    logic        sd_clk = 1'b0;
    logic        rstn, sd_rst;
    logic        sw_req, ac_req;
    logic [5:0]  sw_index;
    logic [31:0] sw_arg, ac_arg;
    logic [1:0]  sw_resp_type;
    logic        cmd_start, cmd_abort, sw_done, ac_done, arb_owner, arb_busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic [1:0]  resp_type;
    logic [3:0]  cmd_err;
    logic        cmd_busy, cmd_done;
    logic        ev_to, ev_idx, ev_crc, ev_end;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  typ;
    } start_t;

    typedef struct packed {
        logic       owner;
        logic [3:0] err;
    } done_t;

    start_t start_q[$];
    done_t  done_q[$];
    int     checks = 0;
    int     errors = 0;

    always #5 sd_clk = ~sd_clk;

    sdio_cmd_arb dut (
        .sd_clk(sd_clk), .rstn(rstn), .sd_rst(sd_rst),
        .sw_req(sw_req), .sw_index(sw_index), .sw_arg(sw_arg), .sw_resp_type(sw_resp_type),
        .ac_req(ac_req), .ac_arg(ac_arg),
        .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
        .resp_type(resp_type), .cmd_abort(cmd_abort),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .cmd_timeout_err_event(ev_to), .resp_index_err_event(ev_idx),
        .resp_crc_err_event(ev_crc), .resp_end_err_event(ev_end),
        .sw_done(sw_done), .ac_done(ac_done), .cmd_err(cmd_err),
        .arb_owner(arb_owner), .arb_busy(arb_busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Command-issue monitor.
    always @(negedge sd_clk) begin
        if (rstn && cmd_start) begin
            if (start_q.size() == 0) begin
                check("start_unexpected", 64'd1, 64'd0);
            end else begin
                start_t e;
                e = start_q.pop_front();
                check("start_fields", {24'd0, cmd_index, cmd_argument, resp_type}, {24'd0, e.idx, e.arg, e.typ});
            end
        end
    end

    // Completion monitor.
    always @(negedge sd_clk) begin
        if (rstn && (sw_done || ac_done)) begin
            check("done_exclusive", {63'd0, sw_done && ac_done}, 64'd0);
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_owner", {63'd0, ac_done}, {63'd0, d.owner});
                check("done_err", {60'd0, cmd_err}, {60'd0, d.err});
            end
        end
    end

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!cmd_start && n < 12) begin
            tick();
            n++;
        end
        if (!cmd_start) check("start_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(sw_done || ac_done) && n < 12) begin
            tick();
            n++;
        end
        if (!(sw_done || ac_done)) check("done_timeout", 64'd0, 64'd1);
    endtask

    // Drives a well-behaved engine from ISSUE through to REPORT.
    task automatic engine_pass(input logic [3:0] ev);
        tick();
        cmd_busy = 1'b1;
        tick();
        cmd_busy = 1'b0;
        cmd_done = 1'b1;
        {ev_end, ev_crc, ev_idx, ev_to} = ev;
        tick();
        cmd_done = 1'b0;
        {ev_end, ev_crc, ev_idx, ev_to} = 4'b0000;
    endtask

    task automatic set_sw(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t);
        sw_index = i;
        sw_arg = a;
        sw_resp_type = t;
        sw_req = 1'b1;
    endtask

    initial begin
        int n;
        rstn = 1'b0; sd_rst = 1'b0; ac_req = 1'b0; ac_arg = 32'd0;
        cmd_busy = 1'b0; cmd_done = 1'b0;
        {ev_end, ev_crc, ev_idx, ev_to} = 4'b0000;

        // Clean software command with the request already high across reset release.
        set_sw(6'd17, 32'h0000_0200, 2'b10);
        start_q.push_back('{6'd17, 32'h0000_0200, 2'b10});
        done_q.push_back('{1'b0, 4'b0000});
        tick(); tick();
        check("rst_busy", {63'd0, arb_busy}, 64'd0);
        check("rst_start", {63'd0, cmd_start}, 64'd0);
        check("rst_err", {60'd0, cmd_err}, 64'd0);
        check("rst_index_arg", {26'd0, cmd_index, cmd_argument}, 64'd0);
        rstn = 1'b1;
        tick();
        check("release_edge1_start", {63'd0, cmd_start}, 64'd0);
        tick();
        check("release_edge2_start", {63'd0, cmd_start}, 64'd1);
        check("release_owner_busy", {62'd0, arb_owner, arb_busy}, 64'd1);
        sw_index = 6'd5;
        sw_arg = 32'd0;
        engine_pass(4'b0000);
        check("index_held", {26'd0, cmd_index, cmd_argument}, {26'd0, 6'd17, 32'h0000_0200});
        wait_done();
        sw_req = 1'b0;
        tick(); tick();

        // Simultaneous requests: auto-CMD12 first, then the pending software command.
        start_q.push_back('{6'd12, 32'd0, 2'b11});
        start_q.push_back('{6'd3, 32'h0000_ABCD, 2'b01});
        done_q.push_back('{1'b1, 4'b0000});
        done_q.push_back('{1'b0, 4'b0000});
        ac_arg = 32'd0;
        ac_req = 1'b1;
        set_sw(6'd3, 32'h0000_ABCD, 2'b01);
        tick();
        check("grant_latency", {63'd0, cmd_start}, 64'd1);
        check("grant_owner_ac", {63'd0, arb_owner}, 64'd1);
        engine_pass(4'b0000);
        wait_done();
        ac_req = 1'b0;
        wait_start();
        check("grant_owner_sw", {63'd0, arb_owner}, 64'd0);
        engine_pass(4'b0000);
        wait_done();
        sw_req = 1'b0;
        tick(); tick();

        // Response timeout reported by the engine while waiting for completion.
        start_q.push_back('{6'd7, 32'd1, 2'b01});
        done_q.push_back('{1'b0, 4'b0001});
        set_sw(6'd7, 32'd1, 2'b01);
        wait_start();
        tick();
        cmd_busy = 1'b1;
        tick();
        cmd_busy = 1'b0;
        ev_to = 1'b1;
        tick();
        ev_to = 1'b0;
        check("timeout_abort", {63'd0, cmd_abort}, 64'd1);
        tick();
        check("timeout_abort_once", {62'd0, cmd_abort, sw_done}, 64'd1);
        wait_done();
        sw_req = 1'b0;
        tick(); tick();

        // CRC error coincident with cmd_done.
        start_q.push_back('{6'd9, 32'h1234_5678, 2'b10});
`ifdef SDIO_CMD_ARB_RETRY_EN
        start_q.push_back('{6'd9, 32'h1234_5678, 2'b10});
        done_q.push_back('{1'b0, 4'b0000});
`else
        done_q.push_back('{1'b0, 4'b0100});
`endif
        set_sw(6'd9, 32'h1234_5678, 2'b10);
        wait_start();
        engine_pass(4'b0100);
`ifdef SDIO_CMD_ARB_RETRY_EN
        wait_start();
        engine_pass(4'b0000);
`endif
        wait_done();
        sw_req = 1'b0;
        tick(); tick();

        // cmd_busy never asserts: the guard counter aborts.
        start_q.push_back('{6'd20, 32'd2, 2'b01});
        done_q.push_back('{1'b0, 4'b0001});
        set_sw(6'd20, 32'd2, 2'b01);
        wait_start();
        n = 0;
        while (!cmd_abort && n < 10) begin
            tick();
            n++;
        end
        check("guard_cycles", 64'(n), 64'd5);
        tick();
        wait_done();
        sw_req = 1'b0;
        tick(); tick();

        // Soft reset in WAIT_DONE: back to IDLE at once, no completion pulse.
        start_q.push_back('{6'd21, 32'd3, 2'b10});
        set_sw(6'd21, 32'd3, 2'b10);
        wait_start();
        tick();
        cmd_busy = 1'b1;
        tick();
        cmd_busy = 1'b0;
        sd_rst = 1'b1;
        sw_req = 1'b0;
        tick();
        sd_rst = 1'b0;
        check("srst_busy", {63'd0, arb_busy}, 64'd0);
        check("srst_index", {58'd0, cmd_index}, 64'd0);
        repeat (6) tick();

        check("sb_drain", 64'(start_q.size() + done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
